fpu_host_seq: RTL and testbench
===============================

# fpu_host_seq

Host-side sequencer for the FPU register bus: accepts a 32-bit operand pair plus opcode on a wide valid/ready port and performs the byte-wide register writes that start an FPU command. It then waits for `cmd_end`, reads the 32-bit result back, acknowledges via `end_ack` and returns the result on a valid/ready response port. It sits between a CPU-side or DMA-side requester and the `fpu` top, and is the initiator for which `fpu` is the responder.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: max cycles waiting for `fpu_cmd_end` before aborting with error; 0 disables timeout.

Ports (`clk` single clock; `arst` asynchronous, active-high reset):
- `clk` in 1: clock, all state on rising edge
- `arst` in 1: async active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted when `req_valid & req_ready`
- `req_op` in 8: opcode (`pa_fpu` op encoding, e.g. `op_mul`)
- `req_a` in 32: operand A, IEEE-754 single
- `req_b` in 32: operand B
- `rsp_valid` out 1: result present
- `rsp_ready` in 1: result consumed when `rsp_valid & rsp_ready`
- `rsp_result` out 32: result word
- `rsp_error` out 1: 1 = timeout abort; `rsp_result` is then 0
- `fpu_addr` out 6: register address
- `fpu_data_out` out 8: write data to FPU `databus_in`
- `fpu_data_in` in 8: read data from FPU `databus_out`
- `fpu_cs`, `fpu_rd`, `fpu_wr` out 1 each: active-low strobes
- `fpu_end_ack` out 1: active-high end acknowledge
- `fpu_cmd_end` in 1: FPU command complete
- `fpu_busy` in 1: FPU operation in progress

## Operation
- Register map: A bytes 0x00–0x03, B bytes 0x04–0x07 (LSB first), opcode 0x08, result bytes 0x10–0x13 (LSB first).
- Bus cycle = 2 clocks: strobe clock (`cs=0`, `wr=0` or `rd=0`, `addr`/`data_out` valid) then idle clock (`cs=rd=wr=1`, `addr` held). Only one of `rd`/`wr` low at a time.
- States: IDLE → WR_A (4 cycles) → WR_B (4) → WR_OP (1) → WAIT_END → RD_RES (4) → ACK → RESP → IDLE.
- IDLE: `req_ready = !fpu_busy`; on handshake latch `req_op/a/b` into internal registers; inputs are don't-care afterwards.
- WAIT_END: leave when `fpu_cmd_end=1`; timeout counter expiry → ACK with error flag set, RD_RES skipped.
- RD_RES: `fpu_data_in` sampled on the rising edge that ends each strobe clock into result byte [8k+7:8k].
- ACK: `fpu_end_ack=1` until `fpu_cmd_end` sampled 0, then RESP. On timeout path ACK is a single clock.
- RESP: `rsp_valid=1`, `rsp_result`/`rsp_error` stable until handshake; then IDLE.
- Reset values: `req_ready=0` (first IDLE clock after reset may assert), `rsp_valid=0`, `rsp_result=0`, `rsp_error=0`, `fpu_cs=fpu_rd=fpu_wr=1`, `fpu_addr=0`, `fpu_data_out=0`, `fpu_end_ack=0`.
- `arst` mid-operation: return to IDLE immediately with all strobes released; the in-flight command is abandoned and no response is produced.

## Timing
- Request-accept to first strobe: 1 clock.
- Fixed write phase: 18 clocks (9 bus cycles).
- Read phase: 8 clocks; ACK ≥1 clock; RESP ≥1 clock.
- Minimum accept-to-`rsp_valid` latency: 18 + W + 8 + A + 1, where W = clocks in WAIT_END (≥1) and A = clocks in ACK (≥1).
- `fpu_cmd_end` already high on WAIT_END entry: exit after 1 clock.
- Timeout counts WAIT_END clocks; error issued when the count reaches `TIMEOUT_CYCLES`.
- `rsp_ready` held high: RESP lasts 1 clock; next request can be accepted in the following clock.

## Structure
- `pa_fpu` holds the address constants (`FPU_A0`, `FPU_B0`, `FPU_OP`, `FPU_RES0`), the existing op enum and the state enum `e_host_st`.
- Top-level `fpu_host_seq` contains the FSM, 2-bit byte index, strobe-phase bit, timeout counter and the operand/result registers.
- Optional sub-module `fpu_bus_cycle`: issues one 2-clock read or write and pulses `done`.

## Test plan
- Mul: `op_mul`, A=0x42C7FAE1 (99.99), B=0x4331E148 (177.88) against real `fpu` → 9 writes at addr 0..8 with correct bytes, `rsp_result`=0x468AF471, `rsp_error`=0.
- Strobe protocol: every write/read has `cs`/`wr`/`rd` low for exactly 1 clock followed by an idle clock; `rd` and `wr` never low together (assertion).
- Timeout: FPU model never raises `cmd_end`, `TIMEOUT_CYCLES`=16 → no reads, `rsp_error`=1, `rsp_result`=0 after 16 WAIT_END clocks.
- Backpressure: `rsp_ready`=0 for 10 clocks → `rsp_valid`/`rsp_result` stable; `req_ready`=0 for that time.
- Busy gating: `fpu_busy`=1 with `req_valid`=1 → no accept; `busy` drops → accept next clock.
- Reset mid-WR_B: `arst` pulse → strobes high in same clock, `rsp_valid` stays 0; new request completes normally.

Source files
------------

// File: rtl/fpu_host_seq_pkg.sv
// Shared definitions for the FPU host sequencer: register map, opcode
// encoding, sequencer states and a byte-lane helper.
package pa_fpu;

    localparam logic [5:0] FPU_A0   = 6'h00;
    localparam logic [5:0] FPU_B0   = 6'h04;
    localparam logic [5:0] FPU_OP   = 6'h08;
    localparam logic [5:0] FPU_RES0 = 6'h10;

    typedef enum logic [7:0] {
        op_add = 8'h00,
        op_sub = 8'h01,
        op_mul = 8'h02,
        op_div = 8'h03
    } e_fpu_op;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_A     = 3'd1,
        ST_WR_B     = 3'd2,
        ST_WR_OP    = 3'd3,
        ST_WAIT_END = 3'd4,
        ST_RD_RES   = 3'd5,
        ST_ACK      = 3'd6,
        ST_RESP     = 3'd7
    } e_host_st;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [31:0] sh;
        sh = w >> {idx, 3'b000};
        return sh[7:0];
    endfunction

endpackage

// File: rtl/fpu_host_seq.sv
// Host-side sequencer: writes operands/opcode byte-wise to the FPU register
// bus, waits for cmd_end (with timeout), reads the result and returns it.
module fpu_host_seq
    import pa_fpu::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic [5:0]  fpu_addr,
    output logic [7:0]  fpu_data_out,
    input  logic [7:0]  fpu_data_in,
    output logic        fpu_cs,
    output logic        fpu_rd,
    output logic        fpu_wr,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

    e_host_st    state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        ph_q, ph_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
    logic        err_q, err_d;
    logic        rdy_en_q, rdy_en_d, rsp_valid_q, rsp_valid_d;
    logic        cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, end_ack_q, end_ack_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        last_byte_s, strobe_s;

    assign req_ready    = rdy_en_q & ~fpu_busy;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = result_q;
    assign rsp_error    = err_q;
    assign fpu_addr     = addr_q;
    assign fpu_data_out = dout_q;
    assign fpu_cs       = cs_q;
    assign fpu_rd       = rd_q;
    assign fpu_wr       = wr_q;
    assign fpu_end_ack  = end_ack_q;

    // Next-state logic; bus outputs are decoded from the next state so they are registered
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ph_d     = ph_q;
        tmo_d    = tmo_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        err_d    = err_q;
        result_d = result_q;
        last_byte_s = ph_q && (idx_q == 2'd3);

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = ST_WR_A;
                    idx_d   = 2'd0;
                    ph_d    = 1'b0;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_A, ST_WR_B, ST_RD_RES: begin
                ph_d  = ~ph_q;
                idx_d = ph_q ? idx_q + 2'd1 : idx_q;
                if (state_q == ST_RD_RES && !ph_q) begin
                    res_d[{idx_q, 3'b000} +: 8] = fpu_data_in;
                end else begin
                    res_d = res_q;
                end
                if (last_byte_s) begin
                    case (state_q)
                        ST_WR_A: state_d = ST_WR_B;
                        ST_WR_B: state_d = ST_WR_OP;
                        default: state_d = ST_ACK;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_WR_OP: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    state_d = ST_WAIT_END;
                    tmo_d   = '0;
                end else begin
                    state_d = ST_WR_OP;
                end
            end
            ST_WAIT_END: begin
                // cmd_end wins over a timeout expiring on the same clock
                if (fpu_cmd_end) begin
                    state_d = ST_RD_RES;
                    idx_d   = 2'd0;
                    ph_d    = 1'b0;
                end else if (TMO_EN && tmo_q == TMO_LAST) begin
                    state_d = ST_ACK;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_ACK: begin
                if (err_q || !fpu_cmd_end) begin
                    state_d  = ST_RESP;
                    result_d = err_q ? 32'h0000_0000 : res_q;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        strobe_s = (state_d inside {ST_WR_A, ST_WR_B, ST_WR_OP, ST_RD_RES}) && !ph_d;
        cs_d     = ~strobe_s;
        wr_d     = ~(strobe_s && state_d != ST_RD_RES);
        rd_d     = ~(strobe_s && state_d == ST_RD_RES);
        addr_d   = addr_q;
        dout_d   = dout_q;
        case (state_d)
            ST_WR_A: begin
                addr_d = FPU_A0 + {4'b0000, idx_d};
                dout_d = word_byte(a_d, idx_d);
            end
            ST_WR_B: begin
                addr_d = FPU_B0 + {4'b0000, idx_d};
                dout_d = word_byte(b_d, idx_d);
            end
            ST_WR_OP: begin
                addr_d = FPU_OP;
                dout_d = op_d;
            end
            ST_RD_RES: begin
                addr_d = FPU_RES0 + {4'b0000, idx_d};
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
        end_ack_d   = (state_d == ST_ACK);
        rsp_valid_d = (state_d == ST_RESP);
        rdy_en_d    = (state_d == ST_IDLE);
    end

    // State and registered-output update; reset abandons any command in flight
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            ph_q        <= 1'b0;
            tmo_q       <= '0;
            op_q        <= 8'h00;
            a_q         <= 32'h0000_0000;
            b_q         <= 32'h0000_0000;
            res_q       <= 32'h0000_0000;
            result_q    <= 32'h0000_0000;
            err_q       <= 1'b0;
            rdy_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            end_ack_q   <= 1'b0;
            addr_q      <= 6'h00;
            dout_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ph_q        <= ph_d;
            tmo_q       <= tmo_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            result_q    <= result_d;
            err_q       <= err_d;
            rdy_en_q    <= rdy_en_d;
            rsp_valid_q <= rsp_valid_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            end_ack_q   <= end_ack_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
        end
    end

endmodule

// File: tb/tb_fpu_host_seq.sv
// Self-checking bench for fpu_host_seq: a behavioural FPU responder plus a
// transaction-level model predicting every bus event, ack window and response.
module tb_fpu_host_seq;
    import pa_fpu::*;

    logic        clk, arst;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
    logic [7:0]  req_op, fpu_data_out, fpu_data_in;
    logic [31:0] req_a, req_b, rsp_result;
    logic [5:0]  fpu_addr;
    logic        fpu_cs, fpu_rd, fpu_wr, fpu_end_ack, fpu_cmd_end, fpu_busy;

    fpu_host_seq #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .fpu_addr(fpu_addr), .fpu_data_out(fpu_data_out), .fpu_data_in(fpu_data_in),
        .fpu_cs(fpu_cs), .fpu_rd(fpu_rd), .fpu_wr(fpu_wr),
        .fpu_end_ack(fpu_end_ack), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy)
    );

    typedef struct {
        int         cyc;
        bit         wr;
        logic [5:0] addr;
        logic [7:0] data;
    } bus_ev_t;

    bus_ev_t     exp_q[$];
    int          errors = 0, checks = 0, cyc = 0, done_cnt = 0;
    bit          active = 0, t_first = 0;
    int          ack_lo, ack_hi, rsp_cyc, acc_cyc, first_rsp_cyc, wcount, rcount;
    logic [31:0] t_res, last_result;
    logic        t_err, last_err;
    logic [7:0]  obs_w[9];
    logic [31:0] cur_res;
    int          cur_dly, cur_hold;
    bit          cur_tmo;

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural FPU: raises cmd_end cur_dly clocks into WAIT_END, holds it cur_hold ack clocks
    initial begin : fpu_model
        int cnt, hcnt;
        cnt = 0;
        hcnt = 0;
        fpu_cmd_end = 1'b0;
        fpu_data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (arst) begin
                cnt = 0;
                fpu_cmd_end = 1'b0;
            end else begin
                if (!fpu_cs && !fpu_rd) fpu_data_in = 8'(cur_res >> (8 * (int'(fpu_addr) - 16)));
                else fpu_data_in = 8'($urandom);
                if (fpu_end_ack && fpu_cmd_end) begin
                    if (hcnt == 0) fpu_cmd_end = 1'b0;
                    else hcnt--;
                end
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        fpu_cmd_end = 1'b1;
                        hcnt = cur_hold;
                    end
                end
                if (!fpu_cs && !fpu_wr && fpu_addr == 6'h08 && !cur_tmo) cnt = cur_dly + 2;
            end
        end
    end

    // Compare process: predicts the whole transaction at accept time, checks every clock
    initial begin : monitor
        bus_ev_t ev;
        bit stb, prev_stb, exp_v;
        int w, a;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk);
            if (arst) begin
                active = 1'b0;
                exp_q.delete();
                prev_stb = 1'b0;
            end else begin
                stb = !fpu_cs;
                chk_eq("rd_wr_exclusive", fpu_rd | fpu_wr, 1);
                chk_eq("cs_matches_strobe", fpu_cs, fpu_rd & fpu_wr);
                if (prev_stb) chk_eq("idle_after_strobe", fpu_cs, 1);
                if (req_valid && req_ready) begin
                    acc_cyc = cyc;
                    w = cur_tmo ? 16 : cur_dly + 1;
                    a = cur_tmo ? 1 : cur_hold + 1;
                    for (int i = 0; i < 9; i++) begin
                        ev.cyc  = cyc + 1 + 2 * i;
                        ev.wr   = 1'b1;
                        ev.addr = 6'(i);
                        ev.data = (i < 4) ? 8'(req_a >> (8 * i)) :
                                  (i < 8) ? 8'(req_b >> (8 * (i - 4))) : req_op;
                        exp_q.push_back(ev);
                    end
                    if (!cur_tmo) begin
                        for (int j = 0; j < 4; j++) begin
                            ev.cyc  = cyc + 19 + w + 2 * j;
                            ev.wr   = 1'b0;
                            ev.addr = 6'(16 + j);
                            ev.data = 8'h00;
                            exp_q.push_back(ev);
                        end
                    end
                    ack_lo  = cur_tmo ? cyc + 19 + w : cyc + 27 + w;
                    ack_hi  = ack_lo + a - 1;
                    rsp_cyc = ack_hi + 1;
                    t_res   = cur_tmo ? 32'h0 : cur_res;
                    t_err   = cur_tmo;
                    active  = 1'b1;
                    t_first = 1'b1;
                    wcount  = 0;
                    rcount  = 0;
                end
                if (stb) begin
                    chk_eq("strobe_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        ev = exp_q.pop_front();
                        chk_eq("strobe_cycle", cyc, ev.cyc);
                        chk_eq("strobe_is_write", !fpu_wr, ev.wr);
                        chk_eq("strobe_addr", fpu_addr, ev.addr);
                        if (ev.wr) chk_eq("write_data", fpu_data_out, ev.data);
                    end
                    if (!fpu_wr && wcount < 9) obs_w[wcount] = fpu_data_out;
                    if (!fpu_wr) wcount++;
                    if (!fpu_rd) rcount++;
                end
                chk_eq("end_ack", fpu_end_ack, active && cyc >= ack_lo && cyc <= ack_hi);
                exp_v = active && cyc >= rsp_cyc;
                chk_eq("rsp_valid", rsp_valid, exp_v);
                if (exp_v) begin
                    if (t_first) begin
                        first_rsp_cyc = cyc;
                        last_result   = rsp_result;
                        last_err      = rsp_error;
                        t_first       = 1'b0;
                    end
                    chk_eq("rsp_result", rsp_result, t_res);
                    chk_eq("rsp_error", rsp_error, t_err);
                    chk_eq("req_ready_in_resp", req_ready, 0);
                    if (rsp_ready) begin
                        chk_eq("bus_events_left", exp_q.size(), 0);
                        active = 1'b0;
                        done_cnt++;
                    end
                end
                prev_stb = stb;
            end
        end
    end

    task automatic start_req(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int busy_cyc);
        int n;
        bit ok;
        @(posedge clk); #1;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        fpu_busy = (busy_cyc > 0);
        for (int i = 0; i < busy_cyc; i++) begin
            @(negedge clk);
            chk_eq("busy_gate", req_ready, 0);
        end
        if (busy_cyc > 0) begin
            @(posedge clk); #1;
            fpu_busy = 1'b0;
        end
        ok = 1'b0;
        n = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else n++;
        end
        chk_eq("accept_in_time", ok, 1);
        if (busy_cyc > 0) chk_eq("accept_after_busy_drop", n, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom; req_op = 8'($urandom);
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int dly, input int hold, input bit tmo,
                          input int bp, input int busy_cyc);
        int n, d0;
        bit ok;
        cur_res = res; cur_dly = dly; cur_hold = hold; cur_tmo = tmo;
        rsp_ready = (bp == 0);
        d0 = done_cnt;
        start_req(op, a, b, busy_cyc);
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
            n++;
        end
        chk_eq("rsp_in_time", ok, 1);
        if (bp > 0) begin
            repeat (bp) @(posedge clk);
            #1 rsp_ready = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("rsp_handshake", done_cnt != d0, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        arst = 1'b1; req_valid = 1'b0; req_op = 8'h00; req_a = 32'h0; req_b = 32'h0;
        rsp_ready = 1'b1; fpu_busy = 1'b0;
        cur_res = 32'h0; cur_dly = 0; cur_hold = 0; cur_tmo = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_req_ready", req_ready, 0);
        chk_eq("rst_rsp_valid", rsp_valid, 0);
        chk_eq("rst_rsp_result", rsp_result, 32'h0);
        chk_eq("rst_rsp_error", rsp_error, 0);
        chk_eq("rst_strobes", {fpu_cs, fpu_rd, fpu_wr}, 3'b111);
        chk_eq("rst_addr", fpu_addr, 6'h00);
        chk_eq("rst_data_out", fpu_data_out, 8'h00);
        chk_eq("rst_end_ack", fpu_end_ack, 0);
        @(posedge clk); #1 arst = 1'b0;
        repeat (3) @(posedge clk);

        // Directed multiply with literal pins on bytes, result and minimum latency
        run_op(op_mul, 32'h42C7FAE1, 32'h4331E148, 32'h468AF471, 0, 0, 1'b0, 0, 0);
        chk_eq("mul_latency", first_rsp_cyc - acc_cyc, 29);
        chk_eq("mul_a_byte0", obs_w[0], 8'hE1);
        chk_eq("mul_a_byte3", obs_w[3], 8'h42);
        chk_eq("mul_b_byte0", obs_w[4], 8'h48);
        chk_eq("mul_b_byte3", obs_w[7], 8'h43);
        chk_eq("mul_op_byte", obs_w[8], 8'h02);
        chk_eq("mul_result", last_result, 32'h468AF471);
        chk_eq("mul_error", last_err, 0);

        run_op(op_add, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 2, 1'b0, 0, 4);
        run_op(op_sub, 32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 5, 1, 1'b0, 10, 0);

        run_op(op_div, 32'h12345678, 32'h9ABCDEF0, 32'h55AA55AA, 0, 0, 1'b1, 0, 0);
        chk_eq("tmo_latency", first_rsp_cyc - acc_cyc, 36);
        chk_eq("tmo_error", last_err, 1);
        chk_eq("tmo_result", last_result, 32'h0);
        chk_eq("tmo_reads", rcount, 0);

        // Reset during WR_B: strobes release in the same clock, no response appears
        cur_res = 32'h11111111; cur_dly = 0; cur_hold = 0; cur_tmo = 1'b0;
        start_req(op_mul, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk_eq("pre_rst_strobe_addr", fpu_addr, 6'h05);
        #1 arst = 1'b1;
        #1;
        chk_eq("midrst_strobes", {fpu_cs, fpu_rd, fpu_wr}, 3'b111);
        chk_eq("midrst_rsp_valid", rsp_valid, 0);
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        repeat (6) @(posedge clk);
        run_op(op_add, 32'h00000001, 32'h00000002, 32'h87654321, 2, 0, 1'b0, 1, 0);

        for (int t = 0; t < 12; t++) begin
            run_op(8'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 10), $urandom_range(0, 3),
                   ($urandom_range(0, 5) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
